// File: rtl/tapped_ring.sv
// ---------------------------------------------------------------------------
// tapped_ring
//
// A clocked emulation of a tapped inverter ring: a Johnson counter. A chain
// of MAX_LEN one-bit stages shifts every clock. The inverted value of a
// selectable tap point is fed back into stage 0. Tap point k sits at the
// end of BASE_LEN*(k+1) stages. A loop of length L therefore produces a
// square wave of period 2L clocks at 50% duty.
//
// Ports
//   clk  : single clock; all state updates on the rising edge
//   rst  : synchronous, active-high reset; clears every stage and captures tap
//   tap  : ring-length select, L = BASE_LEN*(tap+1)
//   y    : oscillator output, taken from stage L-1
//
// Parameters
//   BASE_LEN : stages per tap step, 1..4096 (MAX_LEN = 8*BASE_LEN)
// ---------------------------------------------------------------------------
module tapped_ring #(
  parameter int unsigned BASE_LEN = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tap,
  output logic       y
);

  localparam int unsigned MAX_LEN = 8 * BASE_LEN;

  logic [MAX_LEN-1:0] stage_reg;
  logic [MAX_LEN-1:0] stage_next;
  logic [2:0]         tap_q_reg;
  logic [2:0]         tap_q_next;

  // One candidate loop end per tap value. The loop length is fixed per
  // tap, so every index below is an elaboration-time constant. That keeps
  // the selection to a plain 8:1 mux on tap_q_reg. No run-time
  // multiply or wide index arithmetic is needed, so nothing can overflow
  // even at the largest BASE_LEN.
  logic [7:0] tap_point;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tap
      assign tap_point[gi] = stage_reg[BASE_LEN * (gi + 1) - 1];
    end
  endgenerate

  // The same mux output drives both the feedback and y. y is therefore
  // exactly s[L-1], with no further logic on its path.
  logic feedback;
  assign feedback = tap_point[tap_q_reg];
  assign y        = feedback;

  // Next state for the non-reset case. A tap change restarts the ring
  // from all-zeros under the new length. Switching the loop length in
  // place could leave a non-Johnson pattern in the active stages and
  // cause runt pulses. Stages beyond L-1 keep shifting but are never
  // selected, so they are harmless.
  always_comb begin
    stage_next = {stage_reg[MAX_LEN-2:0], ~feedback};
    tap_q_next = tap_q_reg;
    if (tap != tap_q_reg) begin
      stage_next = '0;
      tap_q_next = tap;
    end
  end

  // Reset takes priority over both restart and shifting. Capturing tap
  // here means a simultaneous reset and tap change does not trigger a
  // second restart on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
      tap_q_reg <= tap;
    end else begin
      stage_reg <= stage_next;
      tap_q_reg <= tap_q_next;
    end
  end

endmodule

// File: tb/tb_tapped_ring.sv
// ---------------------------------------------------------------------------
// tb_tapped_ring
//
// Three instances share one clock: BASE_LEN 125, 4 and 1.
// The reference model tracks, per instance, the number of running edges
// n since the last start, and the current tap. The expected output after
// an edge is floor(n/L) odd, with L = BASE_LEN*(tap+1). Directed scenarios
// come first, then random resets and tap changes.
// ---------------------------------------------------------------------------
module tb_tapped_ring;

  logic       clk = 1'b0;
  logic [2:0] rst_s;
  logic [2:0] tap_s [3];
  logic [2:0] y_s;

  int base_len [3] = '{125, 4, 1};
  int n_edge   [3];
  int tap_m    [3];
  bit started  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tapped_ring #(.BASE_LEN(125)) u_dut0 (.clk(clk), .rst(rst_s[0]), .tap(tap_s[0]), .y(y_s[0]));
  tapped_ring #(.BASE_LEN(4))   u_dut1 (.clk(clk), .rst(rst_s[1]), .tap(tap_s[1]), .y(y_s[1]));
  tapped_ring #(.BASE_LEN(1))   u_dut2 (.clk(clk), .rst(rst_s[2]), .tap(tap_s[2]), .y(y_s[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the inputs present at the edge,
  // then compare every started instance 1 time unit later.
  task automatic step();
    int len;
    logic exp;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst_s[i]) begin
        n_edge[i]  = 0;
        tap_m[i]   = int'(tap_s[i]);
        started[i] = 1'b1;
      end else if (int'(tap_s[i]) != tap_m[i]) begin
        n_edge[i] = 0;
        tap_m[i]  = int'(tap_s[i]);
      end else begin
        n_edge[i]++;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (started[i]) begin
        len = base_len[i] * (tap_m[i] + 1);
        exp = ((n_edge[i] / len) % 2) == 1;
        chk($sformatf("model_dut%0d_n%0d_L%0d", i, n_edge[i], len), y_s[i], exp);
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, f1, w;
    logic prev;

    for (int i = 0; i < 3; i++) begin
      n_edge[i] = 0; tap_m[i] = 0; started[i] = 1'b0; tap_s[i] = 3'd0;
    end

    // Reset for two cycles, then release.
    rst_s = 3'b111;
    step();
    step();
    chk("reset_dut0", y_s[0], 1'b0);
    chk("reset_dut1", y_s[1], 1'b0);
    chk("reset_dut2", y_s[2], 1'b0);
    rst_s = 3'b000;

    // BASE_LEN=125, tap=0: low through edge 124, high 125..249, low 250..374.
    for (int k = 1; k <= 375; k++) begin
      step();
      if (k == 124 || k == 250 || k == 374) chk($sformatf("base125_low_e%0d", k), y_s[0], 1'b0);
      if (k == 125 || k == 249)             chk($sformatf("base125_high_e%0d", k), y_s[0], 1'b1);
    end

    // BASE_LEN=4 sweep: first rise at L, period 2L, high for L.
    for (int t = 0; t < 8; t++) begin
      rst_s[1] = 1'b1; tap_s[1] = 3'(t);
      step();
      rst_s[1] = 1'b0;
      r1 = -1; r2 = -1; f1 = -1; prev = 1'b0;
      for (int c = 1; c <= 200 && r2 < 0; c++) begin
        step();
        if (y_s[1] === 1'b1 && prev === 1'b0) begin
          if (r1 < 0) r1 = c; else r2 = c;
        end
        if (y_s[1] === 1'b0 && prev === 1'b1 && r1 >= 0 && f1 < 0) f1 = c;
        prev = y_s[1];
      end
      chk_int($sformatf("sweep_tap%0d_first_rise", t), r1, 4 * (t + 1));
      chk_int($sformatf("sweep_tap%0d_period", t), r2 - r1, 8 * (t + 1));
      chk_int($sformatf("sweep_tap%0d_high", t), f1 - r1, 4 * (t + 1));
    end

    // Tap change 1 -> 3 while high: restart, 15 more low edges, rise at 16.
    rst_s[1] = 1'b1; tap_s[1] = 3'd1;
    step();
    rst_s[1] = 1'b0;
    w = 0;
    while (y_s[1] !== 1'b1 && w < 20) begin step(); w++; end
    chk("tapchg_high_reached", y_s[1], 1'b1);
    tap_s[1] = 3'd3;
    step();
    chk("tapchg_restart_low", y_s[1], 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) chk($sformatf("tapchg_hold_low_e%0d", k), y_s[1], 1'b0);
      else        chk("tapchg_rise_e16", y_s[1], 1'b1);
    end
    run(64);

    // tap=2, reset pulse in mid-high phase.
    rst_s[1] = 1'b1; tap_s[1] = 3'd2;
    step();
    rst_s[1] = 1'b0;
    run(14);
    chk("midrst_high_before", y_s[1], 1'b1);
    rst_s[1] = 1'b1;
    step();
    chk("midrst_low_after_reset", y_s[1], 1'b0);
    rst_s[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 11) chk("midrst_low_e11", y_s[1], 1'b0);
      if (k == 12) chk("midrst_rise_e12", y_s[1], 1'b1);
    end
    run(48);

    // BASE_LEN=1: tap 0 toggles every clock; tap 7 gives period 16.
    rst_s[2] = 1'b1; tap_s[2] = 3'd0;
    step();
    chk("len1_e0", y_s[2], 1'b0);
    rst_s[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("len1_e%0d", k), y_s[2], (k % 2) == 1);
    end
    rst_s[2] = 1'b1; tap_s[2] = 3'd7;
    step();
    rst_s[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 8)  chk("len1_tap7_rise_e8", y_s[2], 1'b1);
      if (k == 16) chk("len1_tap7_fall_e16", y_s[2], 1'b0);
    end

    // Reset and tap change on the same edge: one start only.
    rst_s[1] = 1'b1; tap_s[1] = 3'd5;
    step();
    rst_s[1] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 23) chk("rst_tap_same_low_e23", y_s[1], 1'b0);
      if (k == 24) chk("rst_tap_same_rise_e24", y_s[1], 1'b1);
    end
    run(30);

    // Random resets and tap changes on all instances.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 3; i++) begin
        rst_s[i] = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 149) == 0) tap_s[i] = 3'($urandom_range(0, 7));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tapped_ring.md
TAPPED_RING -- requirements
Module: tapped_ring

Interface
REQ-001 Parameter BASE_LEN, default 125: delay stages per tap step, legal range 1..4096.
REQ-002 Derived constant MAX_LEN = 8*BASE_LEN; the default yields 1000 delay stages plus one inverting feedback, 1001 elements total.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tap  input  3  ring-length select; effective loop length L = BASE_LEN*(tap+1).
REQ-006 y    output 1  oscillator output, square wave of period 2L clocks.

Function
REQ-007 The block SHALL be a clocked emulation of a tapped inverter ring, with MAX_LEN one-bit stage registers s[0..MAX_LEN-1].
REQ-008 The block SHALL hold a registered copy tap_q of tap; L SHALL always be computed from tap_q, never directly from tap.
REQ-009 On each running edge (rst=0, tap equal to tap_q), s[0] SHALL load ~s[L-1] and every s[i] with i>=1 SHALL load s[i-1].
REQ-010 Stages at index L and above SHALL keep shifting, but SHALL never affect y or the feedback.
REQ-011 y SHALL equal s[L-1], selected through a mux driven by tap_q; no other logic SHALL sit on the y path.
REQ-012 Timing after a start: edge 1 is the first running edge after reset or restart.
- y SHALL be 0 through edge L-1.
- y SHALL be 1 after edges L through 2L-1.
- y SHALL be 0 after edges 2L through 3L-1, and so on.
- Period SHALL be exactly 2L clocks at 50% duty, with no extra transitions.
REQ-013 Restart on tap change: on an edge with rst=0 and tap different from tap_q, all stages SHALL clear to 0 and tap_q SHALL load tap.
REQ-014 A restart edge SHALL act exactly like a reset edge; the following edge is edge 1 under the new L.
REQ-015 A tap change SHALL never produce a non-Johnson ring pattern, a runt pulse or a duty other than 50%.
REQ-016 Arithmetic: L SHALL be computed without overflow for BASE_LEN up to 4096.
REQ-017 Edge cases:
- tap=7 SHALL use all MAX_LEN stages.
- tap=0 with BASE_LEN=1 SHALL give L=1: y toggles every clock, period 2.
REQ-018 The block SHALL contain no combinational loops and no delay constructs; it SHALL be fully synthesizable.

Reset
REQ-019 On a rising clk edge with rst=1, all stages SHALL be 0, tap_q SHALL load tap, and y SHALL be 0 after that edge.
REQ-020 rst SHALL take priority over restart and over normal shifting.
REQ-021 A reset asserted mid-oscillation SHALL force y=0 at the next edge; after release, timing SHALL follow REQ-012 from edge 1.
REQ-022 Before the first reset, state is don't-care.

Verification
REQ-023 BASE_LEN=125, tap=0, reset 2 cycles then release -> y=0 through edge 124, 1 after edges 125..249, 0 after edges 250..374; period 250 clocks.
REQ-024 BASE_LEN=4, sweep tap 0..7 with a reset before each value -> measured period is 8, 16, 24, ..., 64 clocks, each at 50% duty.
REQ-025 BASE_LEN=4, tap=1 running, change tap to 3 while y=1 -> y=0 after the change edge, held 0 for 15 more edges, rises after edge 16, then period 32.
REQ-026 BASE_LEN=4, tap=2, assert rst for 1 cycle mid-high phase -> y=0 after the reset edge; first rise after edge 12; period 24.
REQ-027 BASE_LEN=1, tap=0 -> y toggles every clock (0,1,0,1 after edges 0..3); tap=7 -> period 16.
REQ-028 With rst and a tap change on the same edge -> behaves as reset, tap_q takes the new tap, and no additional restart occurs on the next edge.
